// File: rtl/uart_frame_scheduler_if.sv
// rtl/uart_frame_scheduler_if.sv - requester/serializer handshake bundle for uart_frame_scheduler
interface uart_frame_scheduler_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]   req_valid;
  logic [8*NUM_CH-1:0] req_data;
  logic [NUM_CH-1:0]   req_ready;
  logic [5:0]          sr_workload;
  logic [43:0]         sr_in_data;
`ifdef UART_PARITY_EN
  logic                parity_odd;

  modport master (
    output req_valid, req_data, sr_workload, parity_odd,
    input  req_ready, sr_in_data
  );

  modport slave (
    input  req_valid, req_data, sr_workload, parity_odd,
    output req_ready, sr_in_data
  );
`else
  modport master (
    output req_valid, req_data, sr_workload,
    input  req_ready, sr_in_data
  );

  modport slave (
    input  req_valid, req_data, sr_workload,
    output req_ready, sr_in_data
  );
`endif
endinterface

// File: rtl/uart_frame_scheduler.sv
// rtl/uart_frame_scheduler.sv - round-robin packer of up to four UART characters per 44-bit serializer frame
// Optional parity (bit9) when UART_PARITY_EN is defined; otherwise bit9 is a second stop bit.
module uart_frame_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_frame_scheduler_if.slave bus,
  output logic [2:0]            grant_id,
  output logic [2:0]            fill,
  output logic [CNT_W-1:0]      frames_sent
);
  logic [10:0]       slot [4];
  logic [2:0]        rr_ptr;
  logic              found;
  logic [2:0]        gnt;
  logic [NUM_CH-1:0] gnt_oh;
  logic [7:0]        gnt_data;
  logic              load;
  logic              can_accept;
  logic              xfer;
  logic              par_bit;
  logic [10:0]       chr;

  assign load       = (bus.sr_workload == 6'd0);
  assign can_accept = rst_n && (fill < 3'd4) && !load;
  assign xfer       = found && can_accept;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    found    = 1'b0;
    gnt      = '0;
    gnt_oh   = '0;
    gnt_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && bus.req_valid[i] && (i == (int'(rr_ptr) + k) % NUM_CH)) begin
          found     = 1'b1;
          gnt       = 3'(i);
          gnt_oh[i] = 1'b1;
          gnt_data  = bus.req_data[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready = can_accept ? gnt_oh : '0;
  assign grant_id      = gnt;

`ifdef UART_PARITY_EN
  assign par_bit = (^gnt_data) ^ bus.parity_odd;
`else
  assign par_bit = 1'b1;
`endif

  assign chr = {1'b1, par_bit, gnt_data, 1'b0};

  assign bus.sr_in_data = rst_n ? {slot[3], slot[2], slot[1], slot[0]} : {44{1'b1}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill        <= 3'd0;
      rr_ptr      <= 3'd0;
      frames_sent <= '0;
      for (int k = 0; k < 4; k++) slot[k] <= 11'h7FF;
    end else if (load) begin
      // Serializer captures sr_in_data on this edge; clear staging for the next frame.
      if (fill != 3'd0) frames_sent <= frames_sent + CNT_W'(1);
      fill <= 3'd0;
      for (int k = 0; k < 4; k++) slot[k] <= 11'h7FF;
    end else if (xfer) begin
      slot[fill[1:0]] <= chr;
      fill            <= fill + 3'd1;
      rr_ptr          <= (gnt == 3'(NUM_CH - 1)) ? 3'd0 : gnt + 3'd1;
    end
  end
endmodule

// File: tb/tb_uart_frame_scheduler.sv
// tb/tb_uart_frame_scheduler.sv - directed self-checking bench for uart_frame_scheduler
module tb_uart_frame_scheduler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  grant_id;
  logic [2:0]  fill;
  logic [15:0] frames_sent;
  int          n_cmp = 0;
  int          n_bad = 0;

  localparam logic [43:0] IDLE = {44{1'b1}};

  uart_frame_scheduler_if #(.NUM_CH(4)) bus ();

  uart_frame_scheduler #(.NUM_CH(4), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .grant_id    (grant_id),
    .fill        (fill),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  logic po;
`ifdef UART_PARITY_EN
  assign bus.parity_odd = po;
`endif

  function automatic logic [10:0] enc(input logic [7:0] b, input logic p);
`ifdef UART_PARITY_EN
    return {1'b1, (^b) ^ p, b, 1'b0};
`else
    return {1'b1, 1'b1, b, 1'b0};
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_data = 32'h13121110;
    bus.sr_workload = 6'd20;
    po = 1'b1;
    tick();
    tick();
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready got %b want 0000", bus.req_ready); end
    n_cmp++; if (bus.sr_in_data !== IDLE) begin n_bad++; $display("FAIL reset_sr got %h want %h", bus.sr_in_data, IDLE); end
    n_cmp++; if (fill !== 3'd0) begin n_bad++; $display("FAIL reset_fill got %0d want 0", fill); end
    n_cmp++; if (frames_sent !== 16'd0) begin n_bad++; $display("FAIL reset_frames got %0d want 0", frames_sent); end
  endtask

  task automatic test_one_byte();
    rst_n = 1'b1;
    bus.req_valid = 4'b0001;
    bus.req_data = 32'h00000055;
    bus.sr_workload = 6'd20;
    po = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL one_ready got %b want 0001", bus.req_ready); end
    n_cmp++; if (grant_id !== 3'd0) begin n_bad++; $display("FAIL one_grant got %0d want 0", grant_id); end
    tick();
    bus.req_valid = 4'b0000;
    #1;
    n_cmp++; if (fill !== 3'd1) begin n_bad++; $display("FAIL one_fill got %0d want 1", fill); end
    n_cmp++; if (bus.sr_in_data !== 44'hFFFFFFFFEAA) begin n_bad++; $display("FAIL one_frame got %h want FFFFFFFFEAA", bus.sr_in_data); end
    bus.sr_workload = 6'd0;
    tick();
    #1;
    n_cmp++; if (fill !== 3'd0) begin n_bad++; $display("FAIL one_fill_after_load got %0d want 0", fill); end
    n_cmp++; if (frames_sent !== 16'd1) begin n_bad++; $display("FAIL one_frames got %0d want 1", frames_sent); end
    bus.sr_workload = 6'd20;
    #1;
    n_cmp++; if (bus.sr_in_data !== IDLE) begin n_bad++; $display("FAIL one_cleared got %h want %h", bus.sr_in_data, IDLE); end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req_valid = 4'hF;
    bus.req_data = 32'h13121110;
    bus.sr_workload = 6'd20;
    po = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++; if (bus.req_ready !== 4'(1 << c)) begin n_bad++; $display("FAIL rr_ready%0d got %b want %b", c, bus.req_ready, 4'(1 << c)); end
      n_cmp++; if (grant_id !== 3'(c)) begin n_bad++; $display("FAIL rr_grant%0d got %0d want %0d", c, grant_id, c); end
      tick();
    end
    #1;
    n_cmp++; if (fill !== 3'd4) begin n_bad++; $display("FAIL rr_fill got %0d want 4", fill); end
    n_cmp++; if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL rr_full_ready got %b want 0000", bus.req_ready); end
    n_cmp++; if (bus.sr_in_data !== {enc(8'h13, 1'b1), enc(8'h12, 1'b1), enc(8'h11, 1'b1), enc(8'h10, 1'b1)}) begin
      n_bad++; $display("FAIL rr_frame got %h", bus.sr_in_data);
    end
    tick();
    #1;
    n_cmp++; if (fill !== 3'd4) begin n_bad++; $display("FAIL rr_fill_hold got %0d want 4", fill); end
    bus.sr_workload = 6'd0;
    tick();
    bus.sr_workload = 6'd20;
    #1;
    n_cmp++; if (frames_sent !== 16'd1) begin n_bad++; $display("FAIL rr_frames got %0d want 1", frames_sent); end
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL rr_wrap_ready got %b want 0001", bus.req_ready); end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_load_collision();
    do_reset();
    bus.sr_workload = 6'd0;
    bus.req_valid = 4'b0100;
    bus.req_data = 32'h00A50000;
    po = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL col_ready_at_load got %b want 0000", bus.req_ready); end
    tick();
    #1;
    n_cmp++; if (fill !== 3'd0) begin n_bad++; $display("FAIL col_fill_at_load got %0d want 0", fill); end
    bus.sr_workload = 6'd20;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_bad++; $display("FAIL col_ready_next got %b want 0100", bus.req_ready); end
    n_cmp++; if (grant_id !== 3'd2) begin n_bad++; $display("FAIL col_grant got %0d want 2", grant_id); end
    tick();
    bus.req_valid = 4'b0000;
    #1;
    n_cmp++; if (fill !== 3'd1) begin n_bad++; $display("FAIL col_fill got %0d want 1", fill); end
    n_cmp++; if (bus.sr_in_data[10:0] !== enc(8'hA5, 1'b1)) begin n_bad++; $display("FAIL col_slot0 got %h want %h", bus.sr_in_data[10:0], enc(8'hA5, 1'b1)); end
    n_cmp++; if (frames_sent !== 16'd0) begin n_bad++; $display("FAIL col_frames got %0d want 0", frames_sent); end
  endtask

  task automatic test_empty_frames();
    do_reset();
    bus.req_valid = 4'b0000;
    for (int p = 0; p < 3; p++) begin
      bus.sr_workload = 6'd0;
      #1;
      n_cmp++; if (bus.sr_in_data !== IDLE) begin n_bad++; $display("FAIL empty_sr%0d got %h want %h", p, bus.sr_in_data, IDLE); end
      tick();
      for (int w = 44; w > 0; w--) begin
        bus.sr_workload = 6'(w);
        tick();
      end
    end
    #1;
    n_cmp++; if (frames_sent !== 16'd0) begin n_bad++; $display("FAIL empty_frames got %0d want 0", frames_sent); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.sr_workload = 6'd20;
    bus.req_valid = 4'b0010;
    bus.req_data = 32'h00003C00;
    tick();
    bus.req_valid = 4'b0000;
    bus.sr_workload = 6'd0;
    tick();
    bus.sr_workload = 6'd20;
    bus.req_valid = 4'b0010;
    tick();
    tick();
    tick();
    bus.req_valid = 4'b0000;
    #1;
    n_cmp++; if (fill !== 3'd3) begin n_bad++; $display("FAIL mid_fill_before got %0d want 3", fill); end
    n_cmp++; if (frames_sent !== 16'd1) begin n_bad++; $display("FAIL mid_frames_before got %0d want 1", frames_sent); end
    do_reset();
    #1;
    n_cmp++; if (fill !== 3'd0) begin n_bad++; $display("FAIL mid_fill got %0d want 0", fill); end
    n_cmp++; if (frames_sent !== 16'd0) begin n_bad++; $display("FAIL mid_frames got %0d want 0", frames_sent); end
    bus.req_valid = 4'hF;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_rrptr_ready got %b want 0001", bus.req_ready); end
    bus.req_valid = 4'b0000;
    bus.sr_workload = 6'd0;
    #1;
    n_cmp++; if (bus.sr_in_data !== IDLE) begin n_bad++; $display("FAIL mid_idle_sr got %h want %h", bus.sr_in_data, IDLE); end
    tick();
    #1;
    n_cmp++; if (frames_sent !== 16'd0) begin n_bad++; $display("FAIL mid_idle_frames got %0d want 0", frames_sent); end
    bus.sr_workload = 6'd20;
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    do_reset();
    bus.sr_workload = 6'd20;
    bus.req_valid = 4'b0001;
    bus.req_data = 32'h00000055;
    po = 1'b0;
    tick();
    po = 1'b1;
    tick();
    bus.req_data = 32'h00000007;
    po = 1'b0;
    tick();
    bus.req_valid = 4'b0000;
    #1;
    n_cmp++; if (fill !== 3'd3) begin n_bad++; $display("FAIL par_fill got %0d want 3", fill); end
    n_cmp++; if (bus.sr_in_data[32:0] !== {11'h60E, 11'h6AA, 11'h4AA}) begin n_bad++; $display("FAIL par_slots got %h want %h", bus.sr_in_data[32:0], {11'h60E, 11'h6AA, 11'h4AA}); end
  endtask
`endif

  initial begin
    test_reset();
    test_one_byte();
    test_round_robin();
    test_load_collision();
    test_empty_frames();
    test_mid_reset();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_frame_scheduler.md
Name: uart_frame_scheduler

Overview:
- Shares the 44-bit TX serializer between NUM_CH byte requesters.
- Round-robin arbitration; packs up to four UART characters of 11 bits each (4 × 11 = 44) into the serializer's next parallel frame.
- Sits between the PCI-side channel buffers and the serializer; sr_in_data is valid at each load point (sr_workload == 0).

Parameters:
- NUM_CH, 4: number of requesting channels (2..8).
- CNT_W, 16: width of the frames-sent counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  NUM_CH  channel i has a byte to send.
- req_data  input  8*NUM_CH  byte of channel i at bits [8i+7:8i].
- req_ready  output  NUM_CH  one-hot grant; a byte transfers when valid & ready on a rising edge.
- sr_workload  input  6  serializer workload; 0 means it loads sr_in_data on this edge.
- sr_in_data  output  44  parallel frame to the serializer.
- grant_id  output  3  index of the currently granted channel (valid when |req_ready).
- fill  output  3  characters staged, 0..4.
- frames_sent  output  CNT_W  count of non-empty frames handed to the serializer.
- parity_odd  input  1  present only with UART_PARITY_EN.

Behaviour:
- Reset (posedge clk with rst_n=0): fill=0, all four slots cleared, rr_ptr=0, frames_sent=0. While rst_n=0: req_ready=0 and sr_in_data=44'hFFFFFFFFFFF (idle mark).
- Reset mid-frame: staged characters are discarded and not sent. The serializer is unaffected and finishes its current frame.
- Character encoding (11 bits, LSB sent first): bit0 start=0; bits8:1 data LSB-first; bit9 parity or extra stop; bit10 stop=1.
- Slot k occupies sr_in_data[11k+10:11k]; slot 0 is sent first.
- sr_in_data is combinational from the staging slots. Unfilled slots read 11'h7FF, so an empty frame is all ones.
- Arbitration: each cycle, grant the first channel with req_valid set, searching rr_ptr, rr_ptr+1, … modulo NUM_CH.
- req_ready for that channel only, and only when all hold: rst_n=1, fill<4, sr_workload!=0. Otherwise req_ready=0.
- req_ready is combinational; no registered latency.
- On transfer: byte is written into slot[fill], fill increments, rr_ptr becomes grant+1 modulo NUM_CH. At most one transfer per cycle.
- rr_ptr is unchanged when nothing transfers.
- Load point (sr_workload==0 on a rising edge):
  - The serializer captures sr_in_data.
  - Scheduler clears all slots and sets fill=0 on the same edge.
  - frames_sent increments if the pre-clear fill was >0; wraps modulo 2^CNT_W.
  - No transfer on that edge (ready is low), so a byte is never lost or duplicated.
- Full (fill=4): all ready low until the next load point.
- Empty load point: idle frame sent, counter unchanged.
- Throughput: at most 4 bytes per serializer period (45 clk cycles: 1 load + 44 shifts).

Optional Feature:
- Macro UART_PARITY_EN.
- Defined: port parity_odd exists; bit9 = (^data) ^ parity_odd, i.e. even parity when parity_odd=0. parity_odd is sampled at byte transfer and stored per slot.
- Undefined: no parity_odd port; bit9 = 1 (two stop bits).

Test Plan:
- Reset, then one byte: rst_n low 2 cycles, then ch0 sends 0x55 with sr_workload=20 → slot0=11'h6AA, fill=1. At sr_workload=0: sr_in_data=44'hFFFFFFFFEAA, then fill=0, frames_sent=1.
- Round-robin: all 4 channels valid continuously with bytes 0x10..0x13 → grants 0,1,2,3 in consecutive cycles. fill reaches 4, ready all low. Next frame order after load starts at ch0 again.
- Load collision: ch2 valid on the cycle sr_workload=0 → req_ready=0, no transfer. Byte is accepted the next cycle into slot0 of the new frame.
- Empty frames: no requests across 3 serializer periods → sr_in_data=all ones, frames_sent unchanged.
- Mid-operation reset: fill=3, then rst_n low 1 cycle → fill=0, rr_ptr=0, frames_sent=0. Next load is an idle frame.
- UART_PARITY_EN: 0x55 with parity_odd=0 → slot=11'h4AA; with parity_odd=1 → 11'h6AA. 0x07 with parity_odd=0 → 11'h60E.
